dll_tap_controller: RTL and testbench



---
 rtl/dll_pkg.sv | 7 +
 rtl/dll_tap_decode.sv | 14 +
 rtl/dll_tap_controller.sv | 126 ++++++++++++
 tb/tb_dll_tap_controller.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// dll_pkg: shared state encoding and default sizing for the DLL tap controller.
package dll_pkg;
    typedef enum logic [1:0] {IDLE, SAR, TRACK} state_t;
    localparam int N_CELLS_DEF = 16;
    localparam int SETTLE_DEF  = 4;
    localparam int FILT_DEF    = 4;
endpackage

// File: rtl/dll_tap_decode.sv
// dll_tap_decode: tap code to one-hot turn-back (T) and thermometer forward-pass (Tb) vectors.
module dll_tap_decode #(
    parameter int N_CELLS = 16,
    parameter int TAP_W   = $clog2(N_CELLS)
) (
    input  logic [TAP_W-1:0]   i_tap,
    output logic [N_CELLS-1:0] o_t,
    output logic [N_CELLS-1:0] o_tb
);
    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
        assign o_t[k]  = (i_tap == TAP_W'(k));
        assign o_tb[k] = (TAP_W'(k) < i_tap);
    end
endmodule

// File: rtl/dll_tap_controller.sv
// dll_tap_controller: SAR lock acquisition then filtered up/down tracking of the DDC delay-line tap.
module dll_tap_controller
    import dll_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int TAP_W   = $clog2(N_CELLS),
    parameter int SETTLE  = SETTLE_DEF,
    parameter int FILT    = FILT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock_en,
    input  logic               pd_up,
    input  logic               pd_dn,
    output logic [N_CELLS-1:0] T,
    output logic [N_CELLS-1:0] Tb,
    output logic [TAP_W-1:0]   tap,
    output logic               locked,
    output logic               range_err
);
    localparam int BIT_W = (TAP_W > 1) ? $clog2(TAP_W) : 1;
    localparam int FW    = 5;

    state_t               r_state;
    logic [TAP_W-1:0]     r_tap;
    logic [N_CELLS-1:0]   r_t, r_tb;
    logic                 r_locked, r_range_err;
    logic [3:0]           r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic signed [FW-1:0] r_filt;

    logic                 w_settled, w_up, w_dn, w_step_up, w_step_dn, w_sat;
    logic signed [FW-1:0] w_filt_inc;
    logic [TAP_W-1:0]     w_mask, w_kept, w_sar_code, w_tap_nxt;
    logic [N_CELLS-1:0]   w_t, w_tb;

    always_comb begin
        w_settled  = (r_cnt == 4'(SETTLE));
        w_up       = pd_up & ~pd_dn;
        w_dn       = pd_dn & ~pd_up;
        w_filt_inc = r_filt + (w_up ? 5'sd1 : w_dn ? -5'sd1 : 5'sd0);
        w_step_up  = (r_state == TRACK) & w_settled & (w_filt_inc == FW'(FILT));
        w_step_dn  = (r_state == TRACK) & w_settled & (w_filt_inc == FW'(-FILT));
        w_sat      = (w_step_up & (r_tap == TAP_W'(N_CELLS - 1))) | (w_step_dn & (r_tap == '0));
        w_mask     = TAP_W'(1) << r_bit;
        w_kept     = w_up ? r_tap : (r_tap & ~w_mask);
        w_sar_code = (r_bit == '0) ? w_kept : (w_kept | (w_mask >> 1));
        w_tap_nxt  = !lock_en               ? '0 :
                     (r_state == IDLE)      ? TAP_W'(1) << (TAP_W - 1) :
                     (r_state == SAR)       ? (w_settled ? w_sar_code : r_tap) :
                     w_sat                  ? r_tap :
                     w_step_up              ? r_tap + TAP_W'(1) :
                     w_step_dn              ? r_tap - TAP_W'(1) : r_tap;
    end

    // Decode the next tap so T/Tb change on the same edge as tap, glitch-free.
    dll_tap_decode #(.N_CELLS(N_CELLS), .TAP_W(TAP_W)) u_decode (
        .i_tap (w_tap_nxt),
        .o_t   (w_t),
        .o_tb  (w_tb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tap       <= '0;
            r_t         <= N_CELLS'(1);
            r_tb        <= '0;
            r_locked    <= 1'b0;
            r_range_err <= 1'b0;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_filt      <= '0;
        end else begin
            r_tap <= w_tap_nxt;
            r_t   <= w_t;
            r_tb  <= w_tb;
            if (!lock_en) begin
                r_state     <= IDLE;
                r_locked    <= 1'b0;
                r_range_err <= 1'b0;
                r_cnt       <= '0;
                r_bit       <= '0;
                r_filt      <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= SAR;
                        r_bit   <= BIT_W'(TAP_W - 1);
                        r_cnt   <= '0;
                    end
                    SAR: begin
                        r_cnt <= w_settled ? '0 : r_cnt + 4'd1;
                        if (w_settled) begin
                            if (r_bit == '0) begin
                                r_state  <= TRACK;
                                r_locked <= 1'b1;
                            end else begin
                                r_bit <= r_bit - BIT_W'(1);
                            end
                        end
                    end
                    TRACK: begin
                        r_cnt <= w_settled ? '0 : r_cnt + 4'd1;
                        if (w_settled) begin
                            r_filt <= (w_step_up | w_step_dn) ? '0 : w_filt_inc;
                            if (w_sat) begin
                                r_range_err <= 1'b1;
                                r_locked    <= 1'b0;
                            end else if (w_step_up | w_step_dn) begin
                                r_locked <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign T         = r_t;
    assign Tb        = r_tb;
    assign tap       = r_tap;
    assign locked    = r_locked;
    assign range_err = r_range_err;
endmodule

// File: tb/tb_dll_tap_controller.sv
// tb_dll_tap_controller: directed and randomized checks against a window-level loop model.
module tb_dll_tap_controller;
    localparam int N = 16, TW = 4, SETTLE = 4, FILT = 4, WIN = SETTLE + 1;

    logic          clk = 1'b0, rst = 1'b1, lock_en = 1'b0, pd_up, pd_dn;
    logic [N-1:0]  T, Tb;
    logic [TW-1:0] tap;
    logic          locked, range_err;

    int thr = 10;
    bit both = 1'b0;
    int checks = 0, failures = 0;
    int m_tap = 0, m_filt = 0;
    bit m_lock = 1'b0, m_rerr = 1'b0;

    always #5 clk = ~clk;

    // Phase detector model: more delay needed while tap <= thr; 'both' forces an invalid (no-vote) pair.
    always_comb begin
        pd_up = both | (int'(tap) <= thr);
        pd_dn = both | !(int'(tap) <= thr);
    end

    dll_tap_controller dut (
        .clk(clk), .rst(rst), .lock_en(lock_en), .pd_up(pd_up), .pd_dn(pd_dn),
        .T(T), .Tb(Tb), .tap(tap), .locked(locked), .range_err(range_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("T_onehot", 64'(T), 64'(1) << tap);
            chk("Tb_thermo", 64'(Tb), (64'(1) << tap) - 1);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_tap"}, 64'(tap), 64'(m_tap));
        chk({tag, "_locked"}, 64'(locked), 64'(m_lock));
        chk({tag, "_range_err"}, 64'(range_err), 64'(m_rerr));
    endtask

    // Binary search reference: each trial adds the next bit, kept only if the PD says "more delay".
    task automatic acquire(input int t);
        int code = 0, trial;
        thr = t;
        lock_en = 1'b1;
        tick(1);
        for (int b = TW - 1; b >= 0; b--) begin
            trial = code | (1 << b);
            chk("sar_trial", 64'(tap), 64'(trial));
            chk("sar_unlocked", 64'(locked), 64'(0));
            tick(WIN - 1);
            chk("sar_hold", 64'(tap), 64'(trial));
            chk("sar_hold_unlocked", 64'(locked), 64'(0));
            if (trial <= t) code = trial;
            tick(1);
        end
        m_tap = code; m_filt = 0; m_lock = 1'b1; m_rerr = 1'b0;
        check_state("acq_final");
    endtask

    task automatic track(input int nw);
        int vote;
        repeat (nw) begin
            tick(WIN);
            vote = both ? 0 : (m_tap <= thr) ? 1 : -1;
            m_filt += vote;
            if (m_filt == FILT || m_filt == -FILT) begin
                if ((m_filt > 0 && m_tap == N - 1) || (m_filt < 0 && m_tap == 0)) begin
                    m_rerr = 1'b1;
                    m_lock = 1'b0;
                end else begin
                    m_tap += (m_filt > 0) ? 1 : -1;
                    m_lock = 1'b1;
                end
                m_filt = 0;
            end
            check_state("track");
        end
    endtask

    task automatic drop();
        lock_en = 1'b0;
        tick(1);
        m_tap = 0; m_lock = 1'b0; m_rerr = 1'b0; m_filt = 0;
        check_state("idle");
    endtask

    initial begin
        tick(2);
        chk("rst_tap", 64'(tap), 64'(0));
        chk("rst_T", 64'(T), 64'h0001);
        chk("rst_Tb", 64'(Tb), 64'h0000);
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_range_err", 64'(range_err), 64'(0));
        rst = 1'b0;
        tick(1);
        check_state("idle_hold");

        acquire(10);
        chk("lock_T", 64'(T), 64'h0400);
        chk("lock_Tb", 64'(Tb), 64'h03FF);
        thr = 11;
        track(4);
        thr = 10;
        track(1);
        both = 1'b1;
        track(8);
        both = 1'b0;
        track(3);
        repeat (6) begin
            thr = int'($urandom_range(0, 15));
            track(int'($urandom_range(2, 10)));
        end

        rst = 1'b1;
        tick(1);
        chk("mid_rst_tap", 64'(tap), 64'(0));
        chk("mid_rst_T", 64'(T), 64'h0001);
        chk("mid_rst_locked", 64'(locked), 64'(0));
        lock_en = 1'b0;
        rst = 1'b0;
        tick(1);

        acquire(15);
        track(4);
        thr = 14;
        track(4);
        drop();

        acquire(-1);
        track(4);
        drop();

        thr = 10;
        lock_en = 1'b1;
        tick(1);
        chk("abort_trial8", 64'(tap), 64'(8));
        tick(WIN);
        chk("abort_trial12", 64'(tap), 64'(12));
        drop();
        acquire(10);
        drop();

        repeat (4) begin
            acquire(int'($urandom_range(0, 15)));
            track(3);
            drop();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
